// File: rtl/nn_complex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_complex_pkg
// Description : Shared state type, mode constants and single-lane evaluator
//               for the nn_complex_array block.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_complex_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } nn_state_t;

    localparam logic MODE_F  = 1'b0;
    localparam logic MODE_NF = 1'b1;

    // mode 1 gives the complemented (AND-OR) form of the gate
    function automatic logic nn_eval(input logic a, input logic b,
                                     input logic c, input logic d,
                                     input logic mode);
        logic r;
        r = ~((c | d) & (~d | (a & b)));
        return (mode == MODE_NF) ? ~r : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_complex_lane.sv
`default_nettype none
// ============================================================================
// Module      : nn_complex_lane
// Description : Combinational evaluation of one nn_complex lane.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_complex_lane
    import nn_complex_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    input  logic i_mode,
    output logic o_f
);

    assign o_f = nn_eval(i_a, i_b, i_c, i_d, i_mode);

endmodule
`default_nettype wire

// File: rtl/nn_complex_array.sv
`default_nettype none
// ============================================================================
// Module      : nn_complex_array
// Description : WIDTH-lane clocked nn_complex gate with programmable settle
//               interval and valid/ready handshakes on both sides.
//               Optional toggle counter enabled by NN_COMPLEX_TOGGLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_complex_array
    import nn_complex_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef NN_COMPLEX_TOGGLE_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt
`endif
);

    localparam logic [7:0] c_settle_init = 8'(SETTLE_CYCLES - 1);

    nn_state_t        r_state;
    nn_state_t        w_state_next;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic             r_mode;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_load_result;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        nn_complex_lane u_lane (
            .i_a    (r_a[gi]),
            .i_b    (r_b[gi]),
            .i_c    (r_c[gi]),
            .i_d    (r_d[gi]),
            .i_mode (r_mode),
            .o_f    (w_result[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        w_accept      = 1'b0;
        w_load_result = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_load_result = 1'b1;
                    w_state_next  = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // operands are captured only at accept so later input changes cannot leak in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 8'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_mode     <= MODE_F;
            r_out_data <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= a;
                r_b    <= b;
                r_c    <= c;
                r_d    <= d;
                r_mode <= mode;
                r_cnt  <= c_settle_init;
            end else if (r_state == SETTLE && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_load_result) r_out_data <= w_result;
        end
    end

    assign out_data = r_out_data;

`ifdef NN_COMPLEX_TOGGLE_EN
    localparam logic [CNT_W-1:0] c_tog_max = '1;

    logic [CNT_W-1:0] r_toggle_cnt;
    logic [WIDTH-1:0] w_diff;
    logic [6:0]       w_pop;
    logic [CNT_W+7:0] w_sum;

    assign w_diff = w_result ^ r_out_data;

    always_comb begin
        w_pop = 7'd0;
        for (int i = 0; i < WIDTH; i++) w_pop = w_pop + 7'(w_diff[i]);
    end

    assign w_sum = (CNT_W+8)'(r_toggle_cnt) + (CNT_W+8)'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle_cnt <= '0;
        end else if (w_load_result) begin
            if (w_sum > (CNT_W+8)'(c_tog_max)) r_toggle_cnt <= c_tog_max;
            else                               r_toggle_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nn_complex_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_complex_array
// Description : Directed, table-driven bench for nn_complex_array
//               (WIDTH=4, SETTLE_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_complex_array;

    localparam int WIDTH         = 4;
    localparam int SETTLE_CYCLES = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c, d;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef NN_COMPLEX_TOGGLE_EN
    logic [15:0]      toggle_cnt;
    logic             sat_in_ready, sat_out_valid;
    logic [WIDTH-1:0] sat_out_data;
    logic [1:0]       sat_toggle_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nn_complex_array #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef NN_COMPLEX_TOGGLE_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

`ifdef NN_COMPLEX_TOGGLE_EN
    nn_complex_array #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (2)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (sat_in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .mode       (mode),
        .out_valid  (sat_out_valid),
        .out_ready  (out_ready),
        .out_data   (sat_out_data),
        .toggle_cnt (sat_toggle_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic       mode;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // full transaction: accept, fixed latency, result check, then consume
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        a = v.a; b = v.b; c = v.c; d = v.d; mode = v.mode; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; c = ~v.c; d = ~v.d; mode = ~v.mode;
        check($sformatf("v%0d in_ready_after_accept", idx), 64'(in_ready), 64'd0);
        for (int i = 1; i < SETTLE_CYCLES; i++) begin
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid_early_%0d", idx, i), 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'd1);
        check($sformatf("v%0d out_data", idx), 64'(out_data), 64'(v.exp));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("v%0d out_valid_after_consume", idx), 64'(out_valid), 64'd0);
        check($sformatf("v%0d in_ready_after_consume", idx), 64'(in_ready), 64'd1);
    endtask

    initial begin
        // lane i of rows 2..5 carries truth-table combo {a,b,c,d} = 4*row_off + i
        vecs[0] = '{4'b0011, 4'b0101, 4'b1100, 4'b1010, 1'b0, 4'b1011};
        vecs[1] = '{4'b0011, 4'b0101, 4'b1100, 4'b1010, 1'b1, 4'b0100};
        vecs[2] = '{4'b0000, 4'b0000, 4'b1100, 4'b1010, 1'b0, 4'b1011};
        vecs[3] = '{4'b0000, 4'b1111, 4'b1100, 4'b1010, 1'b0, 4'b1011};
        vecs[4] = '{4'b1111, 4'b0000, 4'b1100, 4'b1010, 1'b0, 4'b1011};
        vecs[5] = '{4'b1111, 4'b1111, 4'b1100, 4'b1010, 1'b0, 4'b0001};
        vecs[6] = '{4'b1111, 4'b1111, 4'b1100, 4'b1010, 1'b1, 4'b1110};
        vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1111};
        vecs[8] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0; mode = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
`ifdef NN_COMPLEX_TOGGLE_EN
            if (i == 0) begin
                check("toggle_cnt after 1011", 64'(toggle_cnt), 64'd3);
                check("sat toggle_cnt after 1011", 64'(sat_toggle_cnt), 64'd3);
            end
            if (i == 1) begin
                check("toggle_cnt after 0100", 64'(toggle_cnt), 64'd7);
                check("sat toggle_cnt saturated", 64'(sat_toggle_cnt), 64'd3);
            end
`endif
        end

        // backpressure with ignored in_valid pulses
        @(negedge clk);
        a = 4'b0011; b = 4'b0101; c = 4'b1100; d = 4'b1010; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (SETTLE_CYCLES) @(posedge clk);
        #1;
        check("bp out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 4'(i); b = 4'b1111; c = 4'b0000; d = 4'b0000; mode = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d out_data", i), 64'(out_data), 64'hb);
            check($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp no_stray_accept_%0d", i), 64'(in_ready), 64'd1);
        end

        // reset one cycle after accept; out_data holds 1011 going in
        @(negedge clk);
        a = 4'b1111; b = 4'b1111; c = 4'b0000; d = 4'b0000; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid-settle rst out_valid", 64'(out_valid), 64'd0);
        check("mid-settle rst out_data", 64'(out_data), 64'd0);
        check("mid-settle rst in_ready", 64'(in_ready), 64'd1);
`ifdef NN_COMPLEX_TOGGLE_EN
        check("mid-settle rst toggle_cnt", 64'(toggle_cnt), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("post-rst out_valid_%0d", i), 64'(out_valid), 64'd0);
            check($sformatf("post-rst out_data_%0d", i), 64'(out_data), 64'd0);
        end

        run_vec(vecs[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
